// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bundle: scanner key strobe in, display/commit words out.
// The master side is the scanner and the consumer. The slave side is keypad_entry_ctrl.
interface keypad_entry_ctrl_if;
    logic [3:0]  i_key_code;
    logic        i_key_valid;
    logic [15:0] o_value;
    logic [3:0]  o_blank;
    logic [2:0]  o_digit_cnt;
    logic        o_commit;
    logic [15:0] o_commit_value;
    logic        o_timeout;

    modport master (
        output i_key_code, i_key_valid,
        input  o_value, o_blank, o_digit_cnt, o_commit, o_commit_value, o_timeout
    );

    modport slave (
        input  i_key_code, i_key_valid,
        output o_value, o_blank, o_digit_cnt, o_commit, o_commit_value, o_timeout
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Multi-digit keypad entry sequencer feeding a 4-digit FND. Digits shift in; BACK, CLEAR and ENTER edit the entry.
// Optional idle auto-clear is enabled by defining ENTRY_TIMEOUT_EN.
//
// state | meaning
// IDLE  | nothing entered, cnt=0, lone 0 shown
// ENTRY | 1..3 digits entered
// FULL  | 4 digits entered, further digits ignored
// SHOW  | committed value displayed, all digits lit
module keypad_entry_ctrl #(
    parameter logic [3:0] KEY_BACK  = 4'hA,
    parameter logic [3:0] KEY_CLEAR = 4'hB,
    parameter logic [3:0] KEY_ENTER = 4'hF
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
`endif
) (
    input  logic               clk,
    input  logic               reset_p,
    keypad_entry_ctrl_if.slave kp
);

    typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_FULL, ST_SHOW} state_t;

    state_t      state_q, state_d;
    logic [15:0] value_q, value_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  blank_q, blank_d;
    logic        commit_q, commit_d;
    logic [15:0] commit_value_q, commit_value_d;
    logic        key_acc;
    logic        in_entry;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
`endif

    assign in_entry = (state_q == ST_ENTRY) || (state_q == ST_FULL);

    always_comb begin
        state_d        = state_q;
        value_d        = value_q;
        cnt_d          = cnt_q;
        commit_d       = 1'b0;
        commit_value_d = commit_value_q;
        key_acc        = 1'b0;

        if (kp.i_key_valid) begin
            if (kp.i_key_code <= 4'd9) begin
                key_acc = 1'b1;
                case (state_q)
                    ST_IDLE, ST_SHOW: begin
                        value_d = {12'h000, kp.i_key_code};
                        cnt_d   = 3'd1;
                        state_d = ST_ENTRY;
                    end
                    ST_ENTRY: begin
                        value_d = {value_q[11:0], kp.i_key_code};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd3) state_d = ST_FULL;
                    end
                    default: ;
                endcase
            end else if (kp.i_key_code == KEY_BACK) begin
                key_acc = 1'b1;
                if (in_entry) begin
                    value_d = value_q >> 4;
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd1) ? ST_IDLE : ST_ENTRY;
                end
            end else if (kp.i_key_code == KEY_CLEAR) begin
                key_acc = 1'b1;
                state_d = ST_IDLE;
                value_d = 16'h0000;
                cnt_d   = 3'd0;
            end else if (kp.i_key_code == KEY_ENTER) begin
                key_acc = 1'b1;
                if (in_entry) begin
                    commit_value_d = value_q;
                    commit_d       = 1'b1;
                    cnt_d          = 3'd0;
                    state_d        = ST_SHOW;
                end
            end
        end

`ifdef ENTRY_TIMEOUT_EN
        // An accepted key on the terminal-count cycle cancels the timeout.
        tmr_d     = '0;
        timeout_d = 1'b0;
        if (!key_acc && in_entry) begin
            if (tmr_q == TMR_TC) begin
                state_d   = ST_IDLE;
                value_d   = 16'h0000;
                cnt_d     = 3'd0;
                timeout_d = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
`endif

        if (state_d == ST_SHOW) blank_d = 4'b0000;
        else                    blank_d = {cnt_d <= 3'd3, cnt_d <= 3'd2, cnt_d <= 3'd1, 1'b0};
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q        <= ST_IDLE;
            value_q        <= 16'h0000;
            cnt_q          <= 3'd0;
            blank_q        <= 4'b1110;
            commit_q       <= 1'b0;
            commit_value_q <= 16'h0000;
`ifdef ENTRY_TIMEOUT_EN
            tmr_q          <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            value_q        <= value_d;
            cnt_q          <= cnt_d;
            blank_q        <= blank_d;
            commit_q       <= commit_d;
            commit_value_q <= commit_value_d;
`ifdef ENTRY_TIMEOUT_EN
            tmr_q          <= tmr_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign kp.o_value        = value_q;
    assign kp.o_blank        = blank_q;
    assign kp.o_digit_cnt    = cnt_q;
    assign kp.o_commit       = commit_q;
    assign kp.o_commit_value = commit_value_q;
`ifdef ENTRY_TIMEOUT_EN
    assign kp.o_timeout      = timeout_q;
`else
    assign kp.o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; timeout cases compile in with ENTRY_TIMEOUT_EN (TIMEOUT_CYCLES=16).
module tb_keypad_entry_ctrl;

    logic clk;
    logic reset_p;
    int   n_chk;
    int   n_err;

    keypad_entry_ctrl_if kp();

`ifdef ENTRY_TIMEOUT_EN
    keypad_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .kp      (kp)
    );
`else
    keypad_entry_ctrl dut (
        .clk     (clk),
        .reset_p (reset_p),
        .kp      (kp)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe one key for one cycle; returns at the negedge where its effect is visible.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        kp.i_key_code  = code;
        kp.i_key_valid = 1'b1;
        @(negedge clk);
        kp.i_key_valid = 1'b0;
    endtask

    task automatic check_disp(input string tag, input logic [15:0] val, input logic [2:0] cnt,
                              input logic [3:0] blank);
        check({tag, ".value"}, 32'(kp.o_value), 32'(val));
        check({tag, ".cnt"},   32'(kp.o_digit_cnt), 32'(cnt));
        check({tag, ".blank"}, 32'(kp.o_blank), 32'(blank));
    endtask

    initial begin
        n_chk          = 0;
        n_err          = 0;
        kp.i_key_code  = 4'h0;
        kp.i_key_valid = 1'b0;
        reset_p        = 1'b1;
        repeat (3) @(negedge clk);
        check_disp("rst", 16'h0000, 3'd0, 4'b1110);
        check("rst.commit", 32'(kp.o_commit), 32'd0);
        check("rst.cval", 32'(kp.o_commit_value), 32'h0);
        check("rst.timeout", 32'(kp.o_timeout), 32'd0);
        reset_p = 1'b0;

        press(4'h1); press(4'h2); press(4'h3);
        check_disp("k123", 16'h0123, 3'd3, 4'b1000);

        press(4'hB);
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        check_disp("full", 16'h9876, 3'd4, 4'b0000);
        press(4'h5);
        check_disp("full_ign", 16'h9876, 3'd4, 4'b0000);
        press(4'hA);
        check_disp("back", 16'h0987, 3'd3, 4'b1000);

        press(4'hB);
        press(4'h4); press(4'h2);
        check_disp("k42", 16'h0042, 3'd2, 4'b1100);
        press(4'hF);
        check("enter.commit", 32'(kp.o_commit), 32'd1);
        check("enter.cval", 32'(kp.o_commit_value), 32'h0042);
        check_disp("show", 16'h0042, 3'd0, 4'b0000);
        @(negedge clk);
        check("enter.commit_drop", 32'(kp.o_commit), 32'd0);
        press(4'hF);
        check("show_enter.commit", 32'(kp.o_commit), 32'd0);
        press(4'hA);
        check_disp("show_back", 16'h0042, 3'd0, 4'b0000);
        press(4'h7);
        check_disp("show_digit", 16'h0007, 3'd1, 4'b1110);
        check("show_digit.cval", 32'(kp.o_commit_value), 32'h0042);

        press(4'hB);
        press(4'hF);
        check("idle_enter.commit", 32'(kp.o_commit), 32'd0);
        check_disp("idle_enter", 16'h0000, 3'd0, 4'b1110);
        press(4'hA);
        check_disp("idle_back", 16'h0000, 3'd0, 4'b1110);
        press(4'h3); press(4'hC);
        check_disp("ign_code", 16'h0003, 3'd1, 4'b1110);
        press(4'h8);
        press(4'hB);
        check_disp("clear", 16'h0000, 3'd0, 4'b1110);
        check("clear.cval", 32'(kp.o_commit_value), 32'h0042);

        press(4'h5); press(4'hA);
        check_disp("back_to_idle", 16'h0000, 3'd0, 4'b1110);
        press(4'hF);
        check("back_idle_enter.commit", 32'(kp.o_commit), 32'd0);

`ifndef ENTRY_TIMEOUT_EN
        press(4'h6);
        repeat (40) @(negedge clk);
        check("no_timeout.flag", 32'(kp.o_timeout), 32'd0);
        check_disp("no_timeout", 16'h0006, 3'd1, 4'b1110);
        press(4'hB);
`endif

        // Asynchronous reset landing mid-cycle in the middle of an entry.
        press(4'h1);
        @(posedge clk);
        #2 reset_p = 1'b1;
        #1;
        check_disp("mid_rst", 16'h0000, 3'd0, 4'b1110);
        check("mid_rst.cval", 32'(kp.o_commit_value), 32'h0);
        @(negedge clk);
        reset_p = 1'b0;

        @(negedge clk);
        kp.i_key_code  = 4'h1;
        kp.i_key_valid = 1'b1;
        @(negedge clk);
        kp.i_key_code  = 4'h2;
        @(negedge clk);
        kp.i_key_valid = 1'b0;
        check_disp("b2b", 16'h0012, 3'd2, 4'b1100);

`ifdef ENTRY_TIMEOUT_EN
        press(4'hB);
        press(4'h5);
        repeat (15) @(negedge clk);
        check("tmo.before", 32'(kp.o_timeout), 32'd0);
        check("tmo.before_val", 32'(kp.o_value), 32'h0005);
        @(negedge clk);
        check("tmo.pulse", 32'(kp.o_timeout), 32'd1);
        check_disp("tmo", 16'h0000, 3'd0, 4'b1110);
        check("tmo.commit", 32'(kp.o_commit), 32'd0);
        @(negedge clk);
        check("tmo.drop", 32'(kp.o_timeout), 32'd0);

        press(4'h5);
        repeat (14) @(negedge clk);
        press(4'h6);
        check("tc_key.timeout", 32'(kp.o_timeout), 32'd0);
        check_disp("tc_key", 16'h0056, 3'd2, 4'b1100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
